// File: rtl/piso4_ce_if.sv
// Parallel-load / serial-out bus for piso4_ce.
// Carries the bit-tick enable, load request, data word and the serial line status.
interface piso4_ce_if;
  logic       ce;
  logic       load;
  logic [3:0] d;
  logic       sout;
  logic       busy;
  logic       done;

  modport master (output ce, load, d, input sout, busy, done);
  modport slave  (input ce, load, d, output sout, busy, done);
endinterface

// File: rtl/piso4_ce.sv
// 4-bit parallel-in serial-out framer: start bit, data LSB first,
// optional even-parity bit and a stop bit. Bit timing is set by the ce tick.
module piso4_ce #(
  parameter bit PARITY_EN = 1'b1
) (
  input logic       clk,
  input logic       clr,
  piso4_ce_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     state, state_next;
  logic [3:0] shreg, shreg_next;
  logic [1:0] cnt, cnt_next;
  logic       par, par_next;
  logic       sout_q, sout_next;
  logic       done_q, done_next;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      shreg  <= 4'b0000;
      cnt    <= 2'd0;
      par    <= 1'b0;
      sout_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      shreg  <= shreg_next;
      cnt    <= cnt_next;
      par    <= par_next;
      sout_q <= sout_next;
      done_q <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
    par_next   = par;
    done_next  = 1'b0;
    sout_next  = 1'b1;

    case (state)
      IDLE: begin
        if (bus.load) begin
          shreg_next = bus.d;
          cnt_next   = 2'd0;
          par_next   = ^bus.d;
          state_next = START;
        end
      end
      START: begin
        if (bus.ce) state_next = DATA;
      end
      DATA: begin
        if (bus.ce) begin
          shreg_next = {1'b0, shreg[3:1]};
          cnt_next   = cnt + 2'd1;
          if (cnt == 2'd3) state_next = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bus.ce) state_next = STOP;
      end
      STOP: begin
        if (bus.ce) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // sout is registered, so it is decoded from where the frame will be after this edge
    case (state_next)
      IDLE:    sout_next = 1'b1;
      START:   sout_next = 1'b0;
      DATA:    sout_next = shreg_next[0];
      PARITY:  sout_next = par_next;
      STOP:    sout_next = 1'b1;
      default: sout_next = 1'b1;
    endcase
  end

  assign bus.sout = sout_q;
  assign bus.done = done_q;
  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_piso4_ce.sv
// Directed bench for piso4_ce with both parity settings side by side,
// checked every cycle against a frame-level model plus hand-computed sequences.
module tb_piso4_ce;

  logic clk = 1'b0;
  logic clr;

  piso4_ce_if bus_p ();
  piso4_ce_if bus_n ();

  piso4_ce #(.PARITY_EN(1'b1)) dut_p (.clk(clk), .clr(clr), .bus(bus_p));
  piso4_ce #(.PARITY_EN(1'b0)) dut_n (.clk(clk), .clr(clr), .bus(bus_n));

  always #10 clk = ~clk;

  int vec_count   = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Frame model: index 0 has the parity bit, index 1 does not
  logic [6:0] m_bits   [2];
  int         m_len    [2];
  int         m_idx    [2];
  bit         m_active [2] = '{1'b0, 1'b0};
  bit         m_done   [2] = '{1'b0, 1'b0};

  function automatic logic [6:0] frame_bits(input bit par_en, input logic [3:0] dv);
    logic [6:0] b;
    b      = '1;
    b[0]   = 1'b0;
    b[4:1] = dv;
    if (par_en) b[5] = ^dv;
    return b;
  endfunction

  function automatic logic exp_sout(input int k);
    return m_active[k] ? m_bits[k][m_idx[k]] : 1'b1;
  endfunction

  always @(posedge clk or posedge clr) begin
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        m_active[k] <= 1'b0;
        m_done[k]   <= 1'b0;
        m_idx[k]    <= 0;
      end else begin
        m_done[k] <= 1'b0;
        if (!m_active[k]) begin
          if (bus_p.load) begin
            m_bits[k]   <= frame_bits(k == 0, bus_p.d);
            m_len[k]    <= (k == 0) ? 7 : 6;
            m_idx[k]    <= 0;
            m_active[k] <= 1'b1;
          end
        end else if (bus_p.ce) begin
          if (m_idx[k] + 1 == m_len[k]) begin
            m_active[k] <= 1'b0;
            m_done[k]   <= 1'b1;
          end else begin
            m_idx[k] <= m_idx[k] + 1;
          end
        end
      end
    end
  end

  task automatic check_output(input string name, input logic act, input logic exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic l, input logic c, input logic [3:0] dv);
    bus_p.load = l;
    bus_n.load = l;
    bus_p.ce   = c;
    bus_n.ce   = c;
    bus_p.d    = dv;
    bus_n.d    = dv;
  endtask

  always begin
    @(posedge clk);
    #5;
    if (chk_en) begin
      check_output("p_sout", bus_p.sout, exp_sout(0));
      check_output("p_busy", bus_p.busy, m_active[0]);
      check_output("p_done", bus_p.done, m_done[0]);
      check_output("n_sout", bus_n.sout, exp_sout(1));
      check_output("n_busy", bus_n.busy, m_active[1]);
      check_output("n_done", bus_n.done, m_done[1]);
    end
  end

  logic [0:6] seq37 = 7'b0101001;
  logic [0:5] seq38 = 6'b001011;
  logic [0:6] seq39 = 7'b0011001;
  logic [0:6] seq40 = 7'b0100011;

  initial begin
    clr = 1'b1;
    apply_stimulus(1'b1, 1'b1, 4'b1111);

    // Clear dominates load/ce/d
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #5;
      chk_en = 1'b1;
      check_output("rst_sout", bus_p.sout, 1'b1);
      check_output("rst_busy", bus_p.busy, 1'b0);
      check_output("rst_done", bus_p.done, 1'b0);
    end
    @(negedge clk);
    clr = 1'b0;
    apply_stimulus(1'b0, 1'b1, 4'b0000);
    @(negedge clk);

    // Basic parity frame, d changed right after the load edge
    apply_stimulus(1'b1, 1'b1, 4'b0101);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #5;
      check_output("basic_sout", bus_p.sout, seq37[i]);
      check_output("basic_busy", bus_p.busy, 1'b1);
      if (i == 0) begin
        @(negedge clk);
        apply_stimulus(1'b0, 1'b1, 4'b1111);
      end
    end
    @(posedge clk);
    #5;
    check_output("basic_done", bus_p.done, 1'b1);
    check_output("basic_idle", bus_p.busy, 1'b0);
    @(posedge clk);
    #5;
    check_output("basic_done_once", bus_p.done, 1'b0);

    // ce every 4th clock, no-parity instance pinned by hand
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      apply_stimulus(k == 0, (k % 4) == 3, (k == 0) ? 4'b1010 : 4'($urandom));
      @(posedge clk);
      #5;
      if (k <= 22) check_output("gate_sout", bus_n.sout, seq38[(k < 3) ? 0 : ((k - 3) / 4 + 1)]);
      if (k == 22) check_output("gate_busy", bus_n.busy, 1'b1);
      if (k == 23) begin
        check_output("gate_done", bus_n.done, 1'b1);
        check_output("gate_idle", bus_n.busy, 1'b0);
      end
    end
    @(negedge clk);
    apply_stimulus(1'b0, 1'b1, 4'b0000);

    // Second load during DATA must be ignored
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      apply_stimulus(k == 0 || k == 2, 1'b1, (k == 2) ? 4'b1111 : 4'b0110);
      @(posedge clk);
      #5;
      if (k <= 6) check_output("ign_sout", bus_p.sout, seq39[k]);
      if (k == 7) check_output("ign_done", bus_p.done, 1'b1);
      if (k >= 8) check_output("ign_busy", bus_p.busy, 1'b0);
    end

    // Abort during data bit 2, then a clean frame
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      apply_stimulus(k == 0, 1'b1, 4'b1011);
      @(posedge clk);
      #5;
    end
    @(negedge clk);
    clr = 1'b1;
    #1;
    check_output("abort_sout", bus_p.sout, 1'b1);
    check_output("abort_busy", bus_p.busy, 1'b0);
    check_output("abort_n_busy", bus_n.busy, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #5;
      check_output("abort_no_done", bus_p.done, 1'b0);
    end
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      apply_stimulus(k == 0, 1'b1, (k == 0) ? 4'b0001 : 4'($urandom));
      @(posedge clk);
      #5;
      if (k <= 6) check_output("after_abort_sout", bus_p.sout, seq40[k]);
      if (k == 7) check_output("after_abort_done", bus_p.done, 1'b1);
    end

    // Load held high out of clear: back-to-back frames, one idle clock apart
    @(negedge clk);
    clr = 1'b1;
    apply_stimulus(1'b1, 1'b1, 4'b0011);
    @(negedge clk);
    clr = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk);
      #5;
      if (k == 0) check_output("b2b_first", bus_p.sout, 1'b0);
      if (k == 7 || k == 15) begin
        check_output("b2b_p_gap_busy", bus_p.busy, 1'b0);
        check_output("b2b_p_gap_sout", bus_p.sout, 1'b1);
        check_output("b2b_p_gap_done", bus_p.done, 1'b1);
      end
      if (k == 8 || k == 16) begin
        check_output("b2b_p_start_sout", bus_p.sout, 1'b0);
        check_output("b2b_p_start_busy", bus_p.busy, 1'b1);
      end
      if (k == 6 || k == 13 || k == 20) begin
        check_output("b2b_n_gap_busy", bus_n.busy, 1'b0);
        check_output("b2b_n_gap_done", bus_n.done, 1'b1);
      end
      if (k == 7 || k == 14) check_output("b2b_n_start_sout", bus_n.sout, 1'b0);
    end

    @(negedge clk);
    apply_stimulus(1'b0, 1'b1, 4'b0000);
    repeat (10) @(posedge clk);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
